tcm_region_router: RTL and testbench

Parametrised N-region memory router between the core's unified load/store port and NUM_REGIONS tightly-coupled memory banks (I-TCM, D-TCM, peripheral TCMs). It decodes the top address bits into a region index and forwards one transaction at a time over a valid/ready request and response handshake. It adds wait-state tolerance, per-region enable masking, a decode-error response and a response timeout. With NUM_REGIONS=2 it reproduces the addr[31] I/D split of the first-generation controller.

---
 rtl/tcm_region_router.sv | 168 ++++++++++++++++
 tb/tb_tcm_region_router.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_region_router.sv
`default_nettype none
// ============================================================================
// Module   : tcm_region_router
// Purpose  : Routes one core load/store at a time to NUM_REGIONS TCM banks,
//            with region masking, decode-error and response-timeout replies.
// Revision : 1.0 - initial release
// ============================================================================
module tcm_region_router #(
  parameter int                     NUM_REGIONS = 4,
  parameter int                     ADDR_W      = 32,
  parameter int                     DATA_W      = 32,
  parameter logic [NUM_REGIONS-1:0] REGION_EN   = '1,
  parameter int                     TIMEOUT     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          core_valid,
  output logic                          core_ready,
  input  logic [ADDR_W-1:0]             core_addr,
  input  logic [DATA_W-1:0]             core_wdata,
  input  logic                          core_we,
  output logic                          core_rvalid,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          core_err,
  output logic [NUM_REGIONS-1:0]        m_req,
  output logic [NUM_REGIONS*ADDR_W-1:0] m_addr,
  output logic [NUM_REGIONS*DATA_W-1:0] m_wdata,
  output logic [NUM_REGIONS-1:0]        m_we,
  input  logic [NUM_REGIONS-1:0]        m_gnt,
  input  logic [NUM_REGIONS-1:0]        m_rvalid,
  input  logic [NUM_REGIONS*DATA_W-1:0] m_rdata
);

  localparam int c_ridx_w = $clog2(NUM_REGIONS);
  localparam int c_cnt_w  = $clog2(TIMEOUT);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_req  = 3'd1;
  localparam logic [2:0] c_st_wait = 3'd2;
  localparam logic [2:0] c_st_resp = 3'd3;
  localparam logic [2:0] c_st_err  = 3'd4;
  localparam logic [2:0] c_st_terr = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic                r_live;
  logic [c_ridx_w-1:0] r_ridx;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [DATA_W-1:0]   r_rdata;
  logic [c_cnt_w-1:0]  r_cnt;

  logic [c_ridx_w-1:0] w_core_ridx;
  logic                w_accept;
  logic                w_gnt;
  logic                w_rvalid;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_limit;
  logic                w_capture;
  logic                w_busy;

  assign w_core_ridx = core_addr[ADDR_W-1 -: c_ridx_w];
  assign w_accept    = core_valid & core_ready;
  assign w_gnt       = m_gnt[r_ridx];
  assign w_rvalid    = m_rvalid[r_ridx];
  assign w_sel_rdata = m_rdata[r_ridx*DATA_W +: DATA_W];
  assign w_limit     = (r_cnt == c_cnt_w'(TIMEOUT - 1));
  assign w_busy      = (r_state == c_st_req) || (r_state == c_st_wait);
  assign w_capture   = ((r_state == c_st_req) && w_gnt && !r_we && w_rvalid) ||
                       ((r_state == c_st_wait) && w_rvalid);

  // r_live holds core_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_next_state = REGION_EN[w_core_ridx] ? c_st_req : c_st_err;
        end
      end
      c_st_req: begin
        if (w_gnt && (r_we || w_rvalid)) begin
          w_next_state = c_st_resp;
        end else if (w_limit) begin
          w_next_state = c_st_terr;
        end else if (w_gnt) begin
          w_next_state = c_st_wait;
        end
      end
      c_st_wait: begin
        if (w_rvalid) begin
          w_next_state = c_st_resp;
        end else if (w_limit) begin
          w_next_state = c_st_terr;
        end
      end
      c_st_resp, c_st_err, c_st_terr: w_next_state = c_st_idle;
      default:                        w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    core_ready  = 1'b0;
    core_rvalid = 1'b0;
    core_err    = 1'b0;
    core_rdata  = '0;
    case (r_state)
      c_st_idle: core_ready = r_live;
      c_st_resp: begin
        core_rvalid = 1'b1;
        core_rdata  = r_rdata;
      end
      c_st_err, c_st_terr: begin
        core_rvalid = 1'b1;
        core_err    = 1'b1;
      end
      default: ;
    endcase
  end

  // r_rdata is cleared on acceptance so writes answer with zero data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ridx  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_ridx  <= w_core_ridx;
        r_addr  <= core_addr;
        r_wdata <= core_wdata;
        r_we    <= core_we;
        r_rdata <= '0;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      if (w_capture) begin
        r_rdata <= w_sel_rdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_slice
    logic w_sel;
    assign w_sel                     = (r_state == c_st_req) && (r_ridx == c_ridx_w'(g));
    assign m_req[g]                  = w_sel;
    assign m_we[g]                   = w_sel & r_we;
    assign m_addr[g*ADDR_W +: ADDR_W] = w_sel ? r_addr : '0;
    assign m_wdata[g*DATA_W +: DATA_W] = w_sel ? r_wdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_tcm_region_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcm_region_router
// Purpose  : Vector table, random transactions and reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcm_region_router;

  localparam int         NR = 4;
  localparam int         AW = 32;
  localparam int         DW = 32;
  localparam int         TO = 16;
  localparam logic [3:0] EN = 4'b1011;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          gdly;
    int          rdly;
    logic [31:0] bdata;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              core_valid = 1'b0;
  logic              core_ready;
  logic [AW-1:0]     core_addr = '0;
  logic [DW-1:0]     core_wdata = '0;
  logic              core_we = 1'b0;
  logic              core_rvalid;
  logic [DW-1:0]     core_rdata;
  logic              core_err;
  logic [NR-1:0]     m_req;
  logic [NR*AW-1:0]  m_addr;
  logic [NR*DW-1:0]  m_wdata;
  logic [NR-1:0]     m_we;
  logic [NR-1:0]     m_gnt = '0;
  logic [NR-1:0]     m_rvalid = '0;
  logic [NR*DW-1:0]  m_rdata = '0;

  int total = 0;
  int bad   = 0;

  tcm_region_router #(
    .NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW), .REGION_EN(EN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_we(core_we),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input int gdly, input int rdly, input logic [31:0] bdata,
                              input int exp_cyc, input logic exp_err, input logic [31:0] exp_data);
    vec_t v;
    v.addr = addr; v.we = we; v.wdata = wdata; v.gdly = gdly; v.rdly = rdly; v.bdata = bdata;
    v.exp_cyc = exp_cyc; v.exp_err = exp_err; v.exp_data = exp_data;
    return v;
  endfunction

  // Reference: the response lands one cycle after the bank completes, unless the
  // completion comes later than cycle TO, in which case an error lands at TO+1.
  function automatic vec_t model(input vec_t v);
    vec_t o;
    int   r;
    int   done;
    o    = v;
    r    = int'(v.addr[31:30]);
    done = v.we ? (1 + v.gdly) : (1 + v.gdly + v.rdly);
    if (!EN[r]) begin
      o.exp_cyc = 1; o.exp_err = 1'b1; o.exp_data = '0;
    end else if (done <= TO) begin
      o.exp_cyc = done + 1; o.exp_err = 1'b0; o.exp_data = v.we ? 32'h0 : v.bdata;
    end else begin
      o.exp_cyc = TO + 1; o.exp_err = 1'b1; o.exp_data = '0;
    end
    return o;
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int            r;
    int            g;
    int            req_end;
    logic [NR-1:0] oh;
    logic [NR-1:0] e_req;
    logic [NR-1:0] e_we;
    logic [NR*AW-1:0] e_addr;
    logic [NR*DW-1:0] e_wdata;
    bit            seen;
    bit            shape_ok;
    int            rcyc;
    logic          rerr;
    logic [31:0]   rdat;
    r        = int'(v.addr[31:30]);
    g        = 1 + v.gdly;
    oh       = 4'b0001 << r;
    req_end  = EN[r] ? ((g < TO) ? g : TO) : 0;
    seen     = 0;
    shape_ok = 1;
    rcyc     = 0;
    rerr     = 1'b0;
    rdat     = '0;
    @(negedge clk);
    for (int k = 0; k < 50 && core_ready !== 1'b1; k++) @(negedge clk);
    check({nm, " ready"}, 64'(core_ready), 64'd1);
    core_valid = 1'b1; core_addr = v.addr; core_wdata = v.wdata; core_we = v.we;
    @(posedge clk);
    @(negedge clk);
    core_valid = 1'b0; core_addr = $urandom; core_wdata = $urandom; core_we = 1'($urandom);
    for (int c = 1; c <= TO + 3 && !seen; c++) begin
      e_req = '0; e_we = '0; e_addr = '0; e_wdata = '0;
      if (c <= req_end) begin
        e_req = oh;
        e_we  = v.we ? oh : '0;
        e_addr[r*AW +: AW]  = v.addr;
        e_wdata[r*DW +: DW] = v.wdata;
      end
      if (m_req !== e_req || m_we !== e_we || m_addr !== e_addr || m_wdata !== e_wdata ||
          core_ready !== 1'b0)
        shape_ok = 0;
      if (core_rvalid === 1'b1) begin
        seen = 1; rcyc = c; rerr = core_err; rdat = core_rdata;
      end
      m_gnt    = 4'($urandom) & ~oh;
      m_rvalid = 4'($urandom) & ~oh;
      m_rdata  = {$urandom, $urandom, $urandom, $urandom};
      m_rdata[r*DW +: DW] = v.bdata;
      if (!seen) begin
        if (c == g) m_gnt = m_gnt | oh;
        if (!v.we && c == g + v.rdly) m_rvalid = m_rvalid | oh;
      end
      @(negedge clk);
    end
    m_gnt = '0; m_rvalid = '0;
    check({nm, " req_shape"}, 64'(shape_ok), 64'd1);
    check({nm, " resp_seen"}, 64'(seen), 64'd1);
    check({nm, " resp_cycle"}, 64'(rcyc), 64'(v.exp_cyc));
    check({nm, " resp_err"}, 64'(rerr), 64'(v.exp_err));
    check({nm, " resp_data"}, 64'(rdat), 64'(v.exp_data));
    check({nm, " post"}, {60'd0, core_rvalid, core_err, |core_rdata, core_ready}, 64'd1);
  endtask

  task automatic mid_reset(input bit in_wait);
    @(negedge clk);
    for (int k = 0; k < 50 && core_ready !== 1'b1; k++) @(negedge clk);
    core_valid = 1'b1; core_addr = 32'hC000_0040; core_we = 1'b0; core_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    core_valid = 1'b0;
    check("midrst req_before", 64'(m_req), 64'h8);
    if (in_wait) begin
      m_gnt = 4'b1000;
      @(negedge clk);
      m_gnt = '0;
      check("midrst wait_noreq", 64'(m_req), 64'h0);
    end
    #2 rst = 1'b1;
    #1 check("midrst async", {58'd0, core_ready, core_rvalid, core_err, |core_rdata, |m_req,
                              |m_addr}, 64'd0);
    m_rvalid = 4'b1000;
    @(negedge clk);
    m_rvalid = '0;
    @(negedge clk);
    check("midrst held", {61'd0, core_ready, core_rvalid, |m_req}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst ready", 64'(core_ready), 64'd1);
    run_txn(mk(32'h4000_0020, 1'b0, 32'h0, 0, 1, 32'h600D_0001, 3, 1'b0, 32'h600D_0001),
            "midrst fresh");
  endtask

  vec_t tbl[11];
  vec_t rv;
  bit   idle_ok;

  initial begin
    tbl[0]  = mk(32'h4000_0010, 1'b0, 32'h0,         0, 0,    32'hDEAD_BEEF, 2,  1'b0, 32'hDEAD_BEEF);
    tbl[1]  = mk(32'hC000_0000, 1'b1, 32'h1234_5678, 3, 0,    32'h5555_AAAA, 5,  1'b0, 32'h0);
    tbl[2]  = mk(32'h8000_0000, 1'b0, 32'h0,         0, 0,    32'h1111_1111, 1,  1'b1, 32'h0);
    tbl[3]  = mk(32'h0000_0200, 1'b0, 32'h0,         2, 13,   32'hCAFE_0001, 17, 1'b0, 32'hCAFE_0001);
    tbl[4]  = mk(32'h0000_0300, 1'b0, 32'h0,         2, 14,   32'hCAFE_0002, 17, 1'b1, 32'h0);
    tbl[5]  = mk(32'h4000_0000, 1'b1, 32'hA5A5_0000, 15, 0,   32'h7777_7777, 17, 1'b0, 32'h0);
    tbl[6]  = mk(32'h4000_0004, 1'b1, 32'hA5A5_0001, 16, 0,   32'h7777_7778, 17, 1'b1, 32'h0);
    tbl[7]  = mk(32'hC000_0100, 1'b0, 32'h0,         1, 2,    32'h0BAD_F00D, 5,  1'b0, 32'h0BAD_F00D);
    tbl[8]  = mk(32'h0000_0000, 1'b1, 32'hFFFF_0000, 0, 0,    32'h1234_0000, 2,  1'b0, 32'h0);
    tbl[9]  = mk(32'hA000_0000, 1'b1, 32'h0000_FFFF, 0, 0,    32'h0,         1,  1'b1, 32'h0);
    tbl[10] = mk(32'h0000_0100, 1'b0, 32'h0,         0, 1000, 32'h3333_3333, 17, 1'b1, 32'h0);

    repeat (2) @(negedge clk);
    check("rst outs", {56'd0, core_ready, core_rvalid, core_err, |core_rdata, |m_req, |m_addr,
                       |m_wdata, |m_we}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst ready_rise", 64'(core_ready), 64'd1);

    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // stray bank strobes while idle must not produce a response
    idle_ok = 1;
    m_gnt = 4'b0001; m_rvalid = 4'b0001; m_rdata = {4{32'hFACE_FACE}};
    @(negedge clk);
    m_gnt = '0; m_rvalid = '0;
    for (int k = 0; k < 3; k++) begin
      if (core_rvalid !== 1'b0 || core_ready !== 1'b1 || m_req !== 4'b0) idle_ok = 0;
      @(negedge clk);
    end
    check("idle stray_rvalid", 64'(idle_ok), 64'd1);

    mid_reset(1'b0);
    mid_reset(1'b1);

    for (int i = 0; i < 40; i++) begin
      rv.addr  = $urandom;
      rv.we    = 1'($urandom);
      rv.wdata = $urandom;
      rv.bdata = $urandom;
      rv.gdly  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 17)) : int'($urandom_range(0, 3));
      rv.rdly  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 16))  : int'($urandom_range(0, 3));
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
